// File: rtl/conv_enc_pkg.sv
// Shared definitions for the parametrised convolutional encoder and its future decoder.
// Holds the default generators, the frame-control state type and the tail-counter sizing helper.
package conv_enc_pkg;

    localparam logic [6:0] CONV_G171 = 7'o171;
    localparam logic [6:0] CONV_G133 = 7'o133;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } enc_state_t;

    // Counter must hold K-2, the first tail index
    function automatic int tail_cnt_width(input int k);
        return $clog2(k);
    endfunction

endpackage

// File: rtl/conv_enc_parity.sv
// Combinational parity network: one XOR-reduced tap set per coded output bit.
// The generators come in on a port so the decoder's branch-metric unit can share this block.
module conv_enc_parity #(
    parameter int K = 7,
    parameter int N = 2
) (
    input  logic [K-1:0]   v,
    input  logic [N*K-1:0] gen,
    output logic [N-1:0]   sym
);

    for (genvar j = 0; j < N; j++) begin : g_out
        assign sym[j] = ^(v & gen[j*K +: K]);
    end

endmodule

// File: rtl/conv_encoder_param.sv
// Rate-1/N feed-forward convolutional encoder with valid/ready on input and output.
// Define CONV_ENC_TAIL_EN to build frame termination with K-1 zero tail symbols; otherwise it streams.
module conv_encoder_param
    import conv_enc_pkg::*;
#(
    parameter int             K   = 7,
    parameter int             N   = 2,
    parameter logic [N*K-1:0] GEN = {CONV_G133, CONV_G171}
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_bit,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sym,
    output logic         out_tail,
    output logic         out_last,
    output logic         busy
);

    logic [K-2:0] s;
    logic         b;
    logic [K-1:0] v;
    logic [N-1:0] sym;
    logic         advance;
    logic         beat;

    // Output register is free this cycle if empty or being drained
    assign advance = !out_valid || out_ready;
    assign v       = {b, s};

    conv_enc_parity #(
        .K(K),
        .N(N)
    ) u_parity (
        .v  (v),
        .gen(GEN),
        .sym(sym)
    );

`ifdef CONV_ENC_TAIL_EN
    localparam int CW = tail_cnt_width(K);

    enc_state_t    state;
    logic [CW-1:0] cnt;

    assign b        = (state == RUN) ? in_bit : 1'b0;
    assign in_ready = (state == RUN) && advance;
    assign beat     = advance && ((state == RUN && in_valid) || state == FLUSH);
    assign busy     = (state != RUN) || out_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            s         <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_sym   <= '0;
            out_tail  <= 1'b0;
            out_last  <= 1'b0;
        end else if (beat) begin
            s         <= v[K-1:1];
            out_sym   <= sym;
            out_valid <= 1'b1;
            case (state)
                RUN: begin
                    out_tail <= 1'b0;
                    out_last <= 1'b0;
                    if (in_last) begin
                        state <= FLUSH;
                        cnt   <= CW'(K - 2);
                    end
                end
                FLUSH: begin
                    out_tail <= 1'b1;
                    out_last <= (cnt == '0);
                    if (cnt == '0) begin
                        state <= RUN;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= RUN;
            endcase
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`else
    assign b        = in_bit;
    assign in_ready = advance;
    assign beat     = advance && in_valid;
    assign busy     = out_valid;
    assign out_tail = 1'b0;

    // Streaming: state carries across frames, in_last only marks the symbol
    always_ff @(posedge clk) begin
        if (reset) begin
            s         <= '0;
            out_valid <= 1'b0;
            out_sym   <= '0;
            out_last  <= 1'b0;
        end else if (beat) begin
            s         <= v[K-1:1];
            out_sym   <= sym;
            out_last  <= in_last;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`endif

endmodule
